fit_stream_arbiter: RTL

//  Shares one fit DSP chain among NCH hit-word requesters. Grants one requester a

---
 rtl/fit_stream_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fit_stream_arbiter.sv
// Round-robin, event-granular arbiter feeding one fit DSP chain from NCH hit-word requesters.
// Optional build macro WATCHDOG_EN adds a stall watchdog that aborts a stuck event.
module fit_stream_arbiter #(
    parameter int NCH       = 4,
    parameter int CHW       = 2,
    parameter int DW        = 32,
    parameter int WCW       = 8,
    parameter int DRAIN_CYC = 3,
    parameter int TMO       = 255
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [NCH-1:0]    REQ_DV,
    input  logic [NCH-1:0]    REQ_EV,
    input  logic [NCH*DW-1:0] REQ_DATA,
    output logic [NCH-1:0]    REQ_ACK,
    input  logic              DSP_BUSY,
    output logic              DSP_DV,
    output logic              DSP_EV,
    output logic [DW-1:0]     DSP_DATA,
    output logic [CHW-1:0]    GRANT_ID,
    output logic              GRANT_VLD,
    output logic [WCW-1:0]    WORD_CNT,
    output logic              ABORT
);

    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    if (NCH < 2 || NCH > 8 || CHW != $clog2(NCH) || DRAIN_CYC < 1 || TMO < 1) begin : g_param_check
        $error("fit_stream_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] win;
    logic [CHW-1:0] ptr_nx;
    logic [CHW:0]   idx;
    logic           found;
    logic           grant_now;
    logic           sel_dv;
    logic           sel_ev;
    logic [DW-1:0]  sel_data;
    logic           xfer;
    logic           abort_now;
    logic [DCW-1:0] drain_cnt;

    // Handshake: a word moves on a rising edge where REQ_DV[i] & REQ_ACK[i]; the
    // requester holds DV/EV/DATA stable until then. ACK is only ever given to the
    // granted channel in STREAM, and it simply mirrors that channel's DV.
    always_comb begin
        sel_dv   = 1'b0;
        sel_ev   = 1'b0;
        sel_data = '0;
        REQ_ACK  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (GRANT_ID == CHW'(i)) begin
                sel_dv   = REQ_DV[i];
                sel_ev   = REQ_EV[i];
                sel_data = REQ_DATA[i*DW +: DW];
            end
            REQ_ACK[i] = (state == ST_STREAM) && (GRANT_ID == CHW'(i)) && REQ_DV[i];
        end
    end

    assign xfer      = (state == ST_STREAM) && sel_dv;
    assign GRANT_VLD = (state == ST_STREAM);

    // Scan from the round-robin pointer, wrapping at NCH (which need not be a power of two).
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = {1'b0, rr_ptr} + (CHW+1)'(i);
            if (idx >= (CHW+1)'(NCH)) begin
                idx = idx - (CHW+1)'(NCH);
            end
            if (!found && REQ_DV[idx[CHW-1:0]]) begin
                found = 1'b1;
                win   = idx[CHW-1:0];
            end
        end
    end

    assign ptr_nx    = (win == CHW'(NCH-1)) ? '0 : win + CHW'(1);
    assign grant_now = (state == ST_IDLE) && found && !DSP_BUSY;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (grant_now) begin
                    state_nx = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if ((xfer && sel_ev) || abort_now) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DCW'(DRAIN_CYC-1)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            DSP_DV    <= 1'b0;
            DSP_EV    <= 1'b0;
            DSP_DATA  <= '0;
            GRANT_ID  <= '0;
            WORD_CNT  <= '0;
            rr_ptr    <= '0;
            drain_cnt <= '0;
        end else begin
            DSP_DV <= xfer | abort_now;
            DSP_EV <= (xfer & sel_ev) | abort_now;
            if (abort_now) begin
                DSP_DATA <= '0;
            end else if (xfer) begin
                DSP_DATA <= sel_data;
            end
            if (grant_now) begin
                GRANT_ID <= win;
                rr_ptr   <= ptr_nx;
                WORD_CNT <= '0;
            end else if (xfer && (WORD_CNT != '1)) begin
                WORD_CNT <= WORD_CNT + 1'b1;
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

`ifdef WATCHDOG_EN
    localparam int SCW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [SCW-1:0] stall_cnt;

    // The TMO-th consecutive idle STREAM cycle closes the event with a zero EV word.
    assign abort_now = (state == ST_STREAM) && !xfer && (stall_cnt == SCW'(TMO-1));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            stall_cnt <= '0;
            ABORT     <= 1'b0;
        end else begin
            ABORT <= abort_now;
            if ((state == ST_STREAM) && !xfer) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`else
    assign abort_now = 1'b0;
    assign ABORT     = 1'b0;
`endif

endmodule
